// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchronizer, mid-bit sampling FSM, and a
// one-cycle valid or frame_error pulse on the cycle after the stop sample.
module uart_rx #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q, prev_q;
    logic             in_sync;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             pend_ok_q, pend_ok_d;
    logic             pend_bad_q, pend_bad_d;
    logic             valid_q, valid_d;
    logic             fe_q, fe_d;

    assign in_sync = sync2_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            pend_ok_q  <= 1'b0;
            pend_bad_q <= 1'b0;
            valid_q    <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            sync1_q    <= in;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            pend_ok_q  <= pend_ok_d;
            pend_bad_q <= pend_bad_d;
            valid_q    <= valid_d;
            fe_q       <= fe_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        idx_d      = idx_q;
        shift_d    = shift_q;
        pend_ok_d  = 1'b0;
        pend_bad_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Edge-triggered so a line stuck low cannot start a new frame.
                if (prev_q && !in_sync) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = in_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {in_sync, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // Leave at mid-stop so a start bit right after it is caught.
                if (cnt_q == BIT_LAST) begin
                    cnt_d      = '0;
                    pend_ok_d  = in_sync;
                    pend_bad_d = !in_sync;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        valid_d = pend_ok_q;
        fe_d    = pend_bad_q;
        data_d  = pend_ok_q ? shift_q : data_q;
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign frame_error = fe_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx at 8 and 16 clocks per bit.
module tb_uart_rx;

    localparam int N8  = 8;
    localparam int N16 = 16;

    logic       clk;
    logic       rst_n;
    logic       in8, in16;
    logic [7:0] data8, data16;
    logic       valid8, valid16, fe8, fe16, busy8, busy16;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int overlap = 0;

    int         v_cyc[$];
    logic [7:0] v_dat[$];
    int         fe_cyc[$];
    int         v16_cyc[$];
    logic [7:0] v16_dat[$];
    int         fe16_cnt = 0;
    logic       busy_log [0:4095];

    uart_rx #(.CLKS_PER_BIT(N8)) dut8 (
        .clock(clk), .reset(rst_n), .in(in8),
        .data(data8), .valid(valid8), .frame_error(fe8), .busy(busy8)
    );

    uart_rx #(.CLKS_PER_BIT(N16)) dut16 (
        .clock(clk), .reset(rst_n), .in(in16),
        .data(data16), .valid(valid16), .frame_error(fe16), .busy(busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        busy_log[cyc[11:0]] = busy8;
        if (valid8) begin
            v_cyc.push_back(cyc);
            v_dat.push_back(data8);
        end
        if (fe8) fe_cyc.push_back(cyc);
        if (valid8 && fe8) overlap++;
        if (valid16) begin
            v16_cyc.push_back(cyc);
            v16_dat.push_back(data16);
        end
        if (fe16) fe16_cnt++;
        if (valid16 && fe16) overlap++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Reference timing: line changes right after edge e, in_sync follows two
    // edges later, so the detection edge is t0 = e+3; the stop sample lands at
    // t0 + n/2 + 9n and the pulse is seen after the following edge.
    function automatic int exp_cyc(input int e, input int n);
        return e + 3 + n / 2 + 9 * n + 1;
    endfunction

    function automatic logic busy_at(input int c);
        logic [31:0] cv;
        cv = c;
        return busy_log[cv[11:0]];
    endfunction

    task automatic clear_logs();
        v_cyc.delete();
        v_dat.delete();
        fe_cyc.delete();
        v16_cyc.delete();
        v16_dat.delete();
        fe16_cnt = 0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic send(input int sel, input logic [7:0] b, input logic stop_bit, output int e);
        logic [9:0] frame;
        int n;
        n = (sel == 0) ? N8 : N16;
        frame = {stop_bit, b, 1'b0};
        e = cyc;
        for (int i = 0; i < 10; i++) begin
            if (sel == 0) in8 = frame[i];
            else in16 = frame[i];
            repeat (n) @(posedge clk);
            #1;
        end
        if (sel == 0) in8 = 1'b1;
        else in16 = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in8 = 1'b1;
        in16 = 1'b1;
        #3;
        checks++; if (data8 !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data8); end
        checks++; if (valid8 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid8); end
        checks++; if (fe8 !== 1'b0) begin errors++; $display("FAIL reset_fe got %b exp 0", fe8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy8); end
        checks++; if (data16 !== 8'h00) begin errors++; $display("FAIL reset_data16 got %h exp 00", data16); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(20);
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy8); end
        checks++; if (v_cyc.size() != 0) begin errors++; $display("FAIL idle_valid got %0d pulses exp 0", v_cyc.size()); end
    endtask

    task automatic test_single();
        int e;
        clear_logs();
        send(0, 8'hAA, 1'b1, e);
        idle(2 * N8);
        checks++; if (v_cyc.size() != 1) begin errors++; $display("FAIL aa_count got %0d exp 1", v_cyc.size()); end
        if (v_cyc.size() >= 1) begin
            checks++; if (v_dat[0] !== 8'hAA) begin errors++; $display("FAIL aa_data got %h exp aa", v_dat[0]); end
            checks++; if (v_cyc[0] != exp_cyc(e, N8)) begin errors++; $display("FAIL aa_cycle got %0d exp %0d", v_cyc[0], exp_cyc(e, N8)); end
        end
        checks++; if (data8 !== 8'hAA) begin errors++; $display("FAIL aa_hold got %h exp aa", data8); end
        checks++; if (busy_at(e + 2) !== 1'b0) begin errors++; $display("FAIL aa_busy_pre got %b exp 0", busy_at(e + 2)); end
        checks++; if (busy_at(e + 3) !== 1'b1) begin errors++; $display("FAIL aa_busy_start got %b exp 1", busy_at(e + 3)); end
        checks++; if (busy_at(e + 78) !== 1'b1) begin errors++; $display("FAIL aa_busy_stop got %b exp 1", busy_at(e + 78)); end
        checks++; if (busy_at(e + 79) !== 1'b0) begin errors++; $display("FAIL aa_busy_end got %b exp 0", busy_at(e + 79)); end
        checks++; if (fe_cyc.size() != 0) begin errors++; $display("FAIL aa_fe got %0d exp 0", fe_cyc.size()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[8];
        int es[8];
        int e;
        bytes[0] = 8'hF0; bytes[1] = 8'h0F; bytes[2] = 8'hCC; bytes[3] = 8'hEE;
        for (int i = 4; i < 8; i++) bytes[i] = 8'($urandom_range(0, 255));
        clear_logs();
        for (int i = 0; i < 8; i++) begin
            send(0, bytes[i], 1'b1, e);
            es[i] = e;
        end
        idle(2 * N8);
        checks++; if (v_cyc.size() != 8) begin errors++; $display("FAIL b2b_count got %0d exp 8", v_cyc.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < v_cyc.size()) begin
                checks++; if (v_dat[i] !== bytes[i]) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, v_dat[i], bytes[i]); end
                checks++; if (v_cyc[i] != exp_cyc(es[i], N8)) begin errors++; $display("FAIL b2b_cycle[%0d] got %0d exp %0d", i, v_cyc[i], exp_cyc(es[i], N8)); end
            end
        end
        checks++; if (fe_cyc.size() != 0) begin errors++; $display("FAIL b2b_fe got %0d exp 0", fe_cyc.size()); end
        checks++; if (overlap != 0) begin errors++; $display("FAIL b2b_overlap got %0d exp 0", overlap); end
    endtask

    task automatic test_random_gaps();
        logic [7:0] bytes[6];
        int es[6];
        int e;
        clear_logs();
        for (int i = 0; i < 6; i++) begin
            bytes[i] = 8'($urandom_range(0, 255));
            send(0, bytes[i], 1'b1, e);
            es[i] = e;
            idle($urandom_range(0, 2 * N8));
        end
        idle(2 * N8);
        checks++; if (v_cyc.size() != 6) begin errors++; $display("FAIL gap_count got %0d exp 6", v_cyc.size()); end
        for (int i = 0; i < 6; i++) begin
            if (i < v_cyc.size()) begin
                checks++; if (v_dat[i] !== bytes[i]) begin errors++; $display("FAIL gap_data[%0d] got %h exp %h", i, v_dat[i], bytes[i]); end
                checks++; if (v_cyc[i] != exp_cyc(es[i], N8)) begin errors++; $display("FAIL gap_cycle[%0d] got %0d exp %0d", i, v_cyc[i], exp_cyc(es[i], N8)); end
            end
        end
    endtask

    task automatic test_glitch();
        int e;
        clear_logs();
        e = cyc;
        in8 = 1'b0;
        idle(2);
        in8 = 1'b1;
        idle(3 * N8);
        checks++; if (busy_at(e + 3) !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise got %b exp 1", busy_at(e + 3)); end
        checks++; if (busy_at(e + 6) !== 1'b1) begin errors++; $display("FAIL glitch_busy_hold got %b exp 1", busy_at(e + 6)); end
        checks++; if (busy_at(e + 7) !== 1'b0) begin errors++; $display("FAIL glitch_busy_drop got %b exp 0", busy_at(e + 7)); end
        checks++; if (v_cyc.size() != 0) begin errors++; $display("FAIL glitch_valid got %0d exp 0", v_cyc.size()); end
        checks++; if (fe_cyc.size() != 0) begin errors++; $display("FAIL glitch_fe got %0d exp 0", fe_cyc.size()); end
    endtask

    task automatic test_frame_error();
        int e1, e2;
        clear_logs();
        send(0, 8'h55, 1'b1, e1);
        send(0, 8'h33, 1'b0, e2);
        idle(3 * N8);
        checks++; if (v_cyc.size() != 1) begin errors++; $display("FAIL fe_valid_count got %0d exp 1", v_cyc.size()); end
        if (v_cyc.size() >= 1) begin
            checks++; if (v_dat[0] !== 8'h55) begin errors++; $display("FAIL fe_first_data got %h exp 55", v_dat[0]); end
        end
        checks++; if (fe_cyc.size() != 1) begin errors++; $display("FAIL fe_count got %0d exp 1", fe_cyc.size()); end
        if (fe_cyc.size() >= 1) begin
            checks++; if (fe_cyc[0] != exp_cyc(e2, N8)) begin errors++; $display("FAIL fe_cycle got %0d exp %0d", fe_cyc[0], exp_cyc(e2, N8)); end
        end
        checks++; if (data8 !== 8'h55) begin errors++; $display("FAIL fe_data_hold got %h exp 55", data8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL fe_busy got %b exp 0", busy8); end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] frame;
        int e;
        clear_logs();
        frame = {1'b1, 8'hC6, 1'b0};
        for (int i = 0; i < 4; i++) begin
            in8 = frame[i];
            idle(N8);
        end
        in8 = frame[4];
        idle(N8 / 2);
        checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b exp 1", busy8); end
        rst_n = 1'b0;
        #1;
        checks++; if (data8 !== 8'h00) begin errors++; $display("FAIL mid_rst_data got %h exp 00", data8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", busy8); end
        checks++; if (valid8 !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", valid8); end
        checks++; if (fe8 !== 1'b0) begin errors++; $display("FAIL mid_rst_fe got %b exp 0", fe8); end
        idle(3);
        in8 = 1'b1;
        rst_n = 1'b1;
        idle(12 * N8);
        checks++; if (v_cyc.size() != 0) begin errors++; $display("FAIL mid_abort_valid got %0d exp 0", v_cyc.size()); end
        checks++; if (fe_cyc.size() != 0) begin errors++; $display("FAIL mid_abort_fe got %0d exp 0", fe_cyc.size()); end
        send(0, 8'h0F, 1'b1, e);
        idle(2 * N8);
        checks++; if (v_cyc.size() != 1) begin errors++; $display("FAIL mid_resume_count got %0d exp 1", v_cyc.size()); end
        if (v_cyc.size() >= 1) begin
            checks++; if (v_dat[0] !== 8'h0F) begin errors++; $display("FAIL mid_resume_data got %h exp 0f", v_dat[0]); end
            checks++; if (v_cyc[0] != exp_cyc(e, N8)) begin errors++; $display("FAIL mid_resume_cycle got %0d exp %0d", v_cyc[0], exp_cyc(e, N8)); end
        end
    endtask

    task automatic test_clks16();
        int e;
        clear_logs();
        send(1, 8'hA5, 1'b1, e);
        idle(2 * N16);
        checks++; if (v16_cyc.size() != 1) begin errors++; $display("FAIL n16_count got %0d exp 1", v16_cyc.size()); end
        if (v16_cyc.size() >= 1) begin
            checks++; if (v16_dat[0] !== 8'hA5) begin errors++; $display("FAIL n16_data got %h exp a5", v16_dat[0]); end
            checks++; if (v16_cyc[0] != exp_cyc(e, N16)) begin errors++; $display("FAIL n16_cycle got %0d exp %0d", v16_cyc[0], exp_cyc(e, N16)); end
        end
        checks++; if (fe16_cnt != 0) begin errors++; $display("FAIL n16_fe got %0d exp 0", fe16_cnt); end
        checks++; if (overlap != 0) begin errors++; $display("FAIL overlap_total got %0d exp 0", overlap); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_random_gaps();
        test_glitch();
        test_frame_error();
        test_reset_mid_frame();
        test_clks16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
